// File: rtl/fp_mult_iter_if.sv
// Handshake bundle for the iterative FP multiplier: operand pair in, result out.
interface fp_mult_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28
);
  logic             in_valid;
  logic             in_ready;
  logic             sign_a;
  logic [EXP_W-1:0] exp_a;
  logic [MAN_W-1:0] mant_a;
  logic             sign_b;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] mant_b;
  logic             out_valid;
  logic             out_ready;
  logic             sign;
  logic [EXP_W-1:0] exp;
  logic [MAN_W-1:0] mant;
  logic             ovf;
  logic             unf;

  modport master (
    output in_valid, sign_a, exp_a, mant_a, sign_b, exp_b, mant_b, out_ready,
    input  in_ready, out_valid, sign, exp, mant, ovf, unf
  );

  modport slave (
    input  in_valid, sign_a, exp_a, mant_a, sign_b, exp_b, mant_b, out_ready,
    output in_ready, out_valid, sign, exp, mant, ovf, unf
  );
endinterface

// File: rtl/fp_mult_iter.sv
// Iterative floating-point multiplier. Shift-add mantissa product, BPC
// multiplier bits per cycle, then a two-step normalise/round and exception pass.
// One operation in flight; fixed latency of N+2 edges from accept to out_valid.
module fp_mult_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28,
  parameter int BPC   = 4,
  parameter int RND   = 1
) (
  input logic          clk,
  input logic          rst_n,
  fp_mult_iter_if.slave io
);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int N    = MAN_W / BPC;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = 2 * MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [PW-1:0]          acc;
  logic [PW-1:0]          ma_sh;
  logic [MAN_W-1:0]       mb_sh;
  logic                   sign_r;
  logic                   zero_r;
  logic signed [EW-1:0]   esum;
  logic                   phase;
  logic [MAN_W-1:0]       m_n;
  logic signed [EW-1:0]   e_n;
  logic                   rdy_r, vld_r, sign_o, ovf_o, unf_o;
  logic [EXP_W-1:0]       exp_o;
  logic [MAN_W-1:0]       mant_o;

  // partial product for the current multiplier digit
  logic [PW-1:0] part;
  assign part = ma_sh * PW'(mb_sh[BPC-1:0]);

  // normalise the finished product and apply rounding
  logic                 hi, guard, sticky, inc;
  logic [MAN_W-1:0]     m_pre, m_rnd;
  logic [MAN_W:0]       m_sum;
  logic signed [EW-1:0] e_pre, e_rnd;
  always_comb begin
    hi     = acc[PW-1];
    m_pre  = hi ? acc[PW-1:MAN_W] : acc[PW-2:MAN_W-1];
    guard  = hi ? acc[MAN_W-1] : acc[MAN_W-2];
    sticky = hi ? |acc[MAN_W-2:0] : |acc[MAN_W-3:0];
    inc    = (RND != 0) && guard && (sticky || m_pre[0]);
    m_sum  = {1'b0, m_pre} + {{MAN_W{1'b0}}, inc};
    e_pre  = esum + {{(EW-1){1'b0}}, hi};
    // carry out of the round collapses to 1.000 at the next binade
    m_rnd  = m_sum[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : m_sum[MAN_W-1:0];
    e_rnd  = m_sum[MAN_W] ? e_pre + EW'(1) : e_pre;
  end

  // control FSM with datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      ma_sh  <= '0;
      mb_sh  <= '0;
      sign_r <= 1'b0;
      zero_r <= 1'b0;
      esum   <= '0;
      phase  <= 1'b0;
      m_n    <= '0;
      e_n    <= '0;
      rdy_r  <= 1'b0;
      vld_r  <= 1'b0;
      sign_o <= 1'b0;
      exp_o  <= '0;
      mant_o <= '0;
      ovf_o  <= 1'b0;
      unf_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rdy_r && io.in_valid) begin
            rdy_r  <= 1'b0;
            acc    <= '0;
            ma_sh  <= PW'(io.mant_a);
            mb_sh  <= io.mant_b;
            cnt    <= CW'(N - 1);
            sign_r <= io.sign_a ^ io.sign_b;
            zero_r <= (io.exp_a == '0) || (io.exp_b == '0);
            esum   <= {2'b00, io.exp_a} + {2'b00, io.exp_b} - EW'(BIAS);
            state  <= MUL;
          end else begin
            rdy_r <= 1'b1;
          end
        end
        MUL: begin
          acc   <= acc + part;
          ma_sh <= ma_sh << BPC;
          mb_sh <= mb_sh >> BPC;
          if (cnt == '0) begin
            phase <= 1'b0;
            state <= NORM;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        NORM: begin
          if (!phase) begin
            m_n   <= m_rnd;
            e_n   <= e_rnd;
            phase <= 1'b1;
          end else begin
            // zero operand beats overflow beats underflow
            sign_o <= sign_r;
            ovf_o  <= 1'b0;
            unf_o  <= 1'b0;
            if (zero_r) begin
              exp_o  <= '0;
              mant_o <= '0;
            end else if (e_n >= EMAX) begin
              exp_o  <= '1;
              mant_o <= '1;
              ovf_o  <= 1'b1;
            end else if (e_n[EW-1] || e_n == '0) begin
              exp_o  <= '0;
              mant_o <= '0;
              unf_o  <= 1'b1;
            end else begin
              exp_o  <= e_n[EXP_W-1:0];
              mant_o <= m_n;
            end
            vld_r <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            vld_r <= 1'b0;
            ovf_o <= 1'b0;
            unf_o <= 1'b0;
            rdy_r <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = rdy_r;
  assign io.out_valid = vld_r;
  assign io.sign      = sign_o;
  assign io.exp       = exp_o;
  assign io.mant      = mant_o;
  assign io.ovf       = ovf_o;
  assign io.unf       = unf_o;
endmodule

// File: tb/tb_fp_mult_iter.sv
// Directed bench: RNE and truncating instances driven in lockstep.
module tb_fp_mult_iter;
  logic clk, rst_n;
  int   n_vec, n_err;

  fp_mult_iter_if #(.EXP_W(8), .MAN_W(28)) if0 ();
  fp_mult_iter_if #(.EXP_W(8), .MAN_W(28)) if1 ();

  fp_mult_iter #(.EXP_W(8), .MAN_W(28), .BPC(4), .RND(1)) u_rne (.clk(clk), .rst_n(rst_n), .io(if0));
  fp_mult_iter #(.EXP_W(8), .MAN_W(28), .BPC(4), .RND(0)) u_trn (.clk(clk), .rst_n(rst_n), .io(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sa; logic [7:0] ea; logic [27:0] ma;
    logic sb; logic [7:0] eb; logic [27:0] mb;
    logic s;  logic [7:0] e;  logic [27:0] m_rne; logic [27:0] m_trn;
    logic ovf; logic unf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic sa, input logic [7:0] ea, input logic [27:0] ma,
                       input logic sb, input logic [7:0] eb, input logic [27:0] mb);
    if0.sign_a = sa; if0.exp_a = ea; if0.mant_a = ma;
    if0.sign_b = sb; if0.exp_b = eb; if0.mant_b = mb;
    if1.sign_a = sa; if1.exp_a = ea; if1.mant_a = ma;
    if1.sign_b = sb; if1.exp_b = eb; if1.mant_b = mb;
  endtask

  // accept one pair, measure latency, check result, optional backpressure
  task automatic run_vec(input int idx, input vec_t v, input int hold);
    int lat;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({t, ".in_ready"}, 64'(if0.in_ready), 64'd1);
    drive(v.sa, v.ea, v.ma, v.sb, v.eb, v.mb);
    if0.in_valid = 1'b1; if1.in_valid = 1'b1;
    if0.out_ready = (hold == 0); if1.out_ready = (hold == 0);
    @(posedge clk); #1;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    // operands must be ignored once accepted
    drive(~v.sa, 8'h55, 28'hFFFFFFF, v.sb, 8'hAA, 28'h1234567);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (if0.out_valid) begin lat = k; break; end
    end
    chk({t, ".lat"}, 64'(lat), 64'd9);
    chk({t, ".sign"}, 64'(if0.sign), 64'(v.s));
    chk({t, ".exp"}, 64'(if0.exp), 64'(v.e));
    chk({t, ".mant"}, 64'(if0.mant), 64'(v.m_rne));
    chk({t, ".ovf"}, 64'(if0.ovf), 64'(v.ovf));
    chk({t, ".unf"}, 64'(if0.unf), 64'(v.unf));
    chk({t, ".trn_vld"}, 64'(if1.out_valid), 64'd1);
    chk({t, ".trn_mant"}, 64'(if1.mant), 64'(v.m_trn));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({t, ".hold_vld"}, 64'(if0.out_valid), 64'd1);
      chk({t, ".hold_rdy"}, 64'(if0.in_ready), 64'd0);
      chk({t, ".hold_mant"}, 64'(if0.mant), 64'(v.m_rne));
      chk({t, ".hold_exp"}, 64'(if0.exp), 64'(v.e));
    end
    @(negedge clk);
    if0.out_ready = 1'b1; if1.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({t, ".drop_vld"}, 64'(if0.out_valid), 64'd0);
    chk({t, ".idle_rdy"}, 64'(if0.in_ready), 64'd1);
    chk({t, ".clr_flags"}, 64'({if0.ovf, if0.unf}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    //          sa  ea    ma            sb  eb    mb            s   e     m_rne         m_trn         ovf unf
    vecs[0]  = '{0, 8'd127, 28'h8000000, 1, 8'd127, 28'h8000000, 1, 8'd127, 28'h8000000, 28'h8000000, 0, 0};
    vecs[1]  = '{0, 8'd127, 28'hC000000, 0, 8'd127, 28'hC000000, 0, 8'd128, 28'h9000000, 28'h9000000, 0, 0};
    vecs[2]  = '{0, 8'd127, 28'h8000001, 0, 8'd127, 28'hC000000, 0, 8'd127, 28'hC000002, 28'hC000001, 0, 0};
    vecs[3]  = '{0, 8'd200, 28'h8000000, 1, 8'd200, 28'h8000000, 1, 8'hFF,  28'hFFFFFFF, 28'hFFFFFFF, 1, 0};
    vecs[4]  = '{1, 8'd10,  28'h8000000, 1, 8'd10,  28'h8000000, 0, 8'd0,   28'h0,       28'h0,       0, 1};
    vecs[5]  = '{1, 8'd0,   28'hC000000, 0, 8'd127, 28'hC000000, 1, 8'd0,   28'h0,       28'h0,       0, 0};
    vecs[6]  = '{0, 8'd254, 28'h8000000, 0, 8'd127, 28'h8000000, 0, 8'd254, 28'h8000000, 28'h8000000, 0, 0};
    vecs[7]  = '{0, 8'd254, 28'h8000000, 0, 8'd128, 28'h8000000, 0, 8'hFF,  28'hFFFFFFF, 28'hFFFFFFF, 1, 0};
    vecs[8]  = '{0, 8'd1,   28'h8000000, 0, 8'd126, 28'h8000000, 0, 8'd0,   28'h0,       28'h0,       0, 1};
    vecs[9]  = '{0, 8'd200, 28'hC000000, 0, 8'd181, 28'hC000000, 0, 8'hFF,  28'hFFFFFFF, 28'hFFFFFFF, 1, 0};
    vecs[10] = '{0, 8'd1,   28'h8000000, 0, 8'd127, 28'h8000000, 0, 8'd1,   28'h8000000, 28'h8000000, 0, 0};

    rst_n = 1'b0;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    if0.out_ready = 1'b1; if1.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst.vld", 64'(if0.out_valid), 64'd0);
    chk("rst.out", 64'({if0.sign, if0.exp, if0.mant, if0.ovf, if0.unf}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.rdy", 64'(if0.in_ready), 64'd1);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i], 0);
    run_vec(11, vecs[1], 5);

    // reset pulse mid-MUL aborts the operation
    @(negedge clk);
    drive(0, 8'd127, 28'hC000000, 0, 8'd127, 28'hC000000);
    if0.in_valid = 1'b1; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    chk("mul.rdy", 64'(if0.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.vld", 64'(if0.out_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort.rdy", 64'(if0.in_ready), 64'd1);
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort.no_vld", 64'(if0.out_valid), 64'd0);
    end

    // reset while a result is held drops out_valid immediately
    @(negedge clk);
    drive(0, 8'd127, 28'hC000000, 0, 8'd127, 28'hC000000);
    if0.in_valid = 1'b1; if1.in_valid = 1'b1;
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    @(posedge clk); #1;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("done.vld", 64'(if0.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstdone.vld", 64'(if0.out_valid), 64'd0);
    chk("rstdone.mant", 64'(if0.mant), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    if0.out_ready = 1'b1; if1.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rstdone.rdy", 64'(if0.in_ready), 64'd1);

    run_vec(12, vecs[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
